// File: rtl/counter_host_pkg.sv
// counter_host_pkg: opcodes, status bytes and parser state encoding shared by counter_host and its serializer.
package counter_host_pkg;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_READ = 8'h02;
    localparam logic [7:0] ST_OK   = 8'h00;
    localparam logic [7:0] ST_ERR  = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG,
        S_ISSUE,
        S_LATCH,
        S_SEND_STATUS,
        S_SEND_DATA,
        S_SEND_ERR
    } state_t;

endpackage

// File: rtl/counter_host_ser.sv
// counter_host_ser: response serializer; emits a status byte followed by the WIDTH-bit value LSB first, or a lone error byte.
//   clk, resetn       : clock, synchronous active-low reset
//   load, data        : capture data and queue ST_OK + NB data bytes
//   load_err          : queue a single ST_ERR byte
//   tx_data, tx_valid : registered response byte stream, held while tx_ready is low
//   tx_ready          : host accepts tx_data
//   done              : final byte of the current frame transfers this cycle
module counter_host_ser
    import counter_host_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             load_err,
    input  logic [WIDTH-1:0] data,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             done
);

    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(NB + 2);

    logic [WIDTH+7:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Frame bytes remaining; the shift register only moves on a transfer, so
    // the captured value and the presented byte are stable under backpressure.
    assign tx_valid = cnt_q != '0;
    assign tx_data  = sh_q[7:0];
    assign done     = tx_valid && tx_ready && cnt_q == CW'(1);

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load) begin
            sh_d  = {data, ST_OK};
            cnt_d = CW'(NB + 1);
        end else if (load_err) begin
            sh_d  = {{WIDTH{1'b0}}, ST_ERR};
            cnt_d = CW'(1);
        end else if (tx_valid && tx_ready) begin
            sh_d  = sh_q >> 8;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/counter_host.sv
// counter_host: byte-stream command parser driving a saturating counter (ADD operand, READ value) with byte responses.
//   clk, resetn                 : clock, synchronous active-low reset
//   rx_data, rx_valid, rx_ready : command byte stream from host
//   tx_data, tx_valid, tx_ready : response byte stream to host
//   cnt_en, cnt_x               : one-cycle increment request to the counter
//   cnt_out                     : current counter value
module counter_host
    import counter_host_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             cnt_en,
    output logic [WIDTH-1:0] cnt_x,
    input  logic [WIDTH-1:0] cnt_out
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB + 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             rx_ready_q, rx_ready_d;
    logic             cnt_en_q, cnt_en_d;
    logic [WIDTH-1:0] cnt_x_q, cnt_x_d;
    logic             rx_fire, tx_fire, bad_op, ser_done;

    assign rx_ready = rx_ready_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_x    = cnt_x_q;
    assign rx_fire  = rx_valid && rx_ready_q;
    assign tx_fire  = tx_valid && tx_ready;
    assign bad_op   = state_q == S_IDLE && rx_fire && rx_data != OP_ADD && rx_data != OP_READ;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opnd_d  = opnd_q;
        case (state_q)
            S_IDLE: if (rx_fire) begin
                idx_d   = '0;
                state_d = rx_data == OP_ADD ? S_ARG : rx_data == OP_READ ? S_LATCH : S_SEND_ERR;
            end
            S_ARG: if (rx_fire) begin
                opnd_d[idx_q*8 +: 8] = rx_data;
                idx_d                = idx_q + 1'b1;
                state_d              = idx_q == IW'(NB - 1) ? S_ISSUE : S_ARG;
            end
            S_ISSUE:       state_d = S_LATCH;
            S_LATCH:       state_d = S_SEND_STATUS;
            S_SEND_STATUS: state_d = tx_fire ? S_SEND_DATA : S_SEND_STATUS;
            S_SEND_DATA,
            S_SEND_ERR:    state_d = ser_done ? S_IDLE : state_q;
            default:       state_d = S_IDLE;
        endcase
        // Handshake and counter strobes are registered off the next state.
        rx_ready_d = state_d == S_IDLE || state_d == S_ARG;
        cnt_en_d   = state_d == S_ISSUE;
        cnt_x_d    = state_d == S_ISSUE ? opnd_d : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            opnd_q     <= '0;
            rx_ready_q <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_x_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            opnd_q     <= opnd_d;
            rx_ready_q <= rx_ready_d;
            cnt_en_q   <= cnt_en_d;
            cnt_x_q    <= cnt_x_d;
        end
    end

    counter_host_ser #(.WIDTH(WIDTH)) u_ser (
        .clk      (clk),
        .resetn   (resetn),
        .load     (state_q == S_LATCH),
        .load_err (bad_op),
        .data     (cnt_out),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_counter_host.sv
// tb_counter_host: directed self-checking bench for counter_host with a saturating counter model.
module tb_counter_host;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cnt_en;
    logic [31:0] cnt_x;
    logic [31:0] cnt_out;

    logic        ld = 1'b0;
    logic [31:0] ld_v = '0;
    logic [32:0] sum;
    int          en_n = 0;
    int          checks = 0;
    int          errors = 0;
    int          snap;

    always #5 clk = ~clk;

    counter_host #(.WIDTH(32)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cnt_en   (cnt_en),
        .cnt_x    (cnt_x),
        .cnt_out  (cnt_out)
    );

    assign sum = {1'b0, cnt_out} + {1'b0, cnt_x};

    always_ff @(posedge clk) begin
        if (ld) cnt_out <= ld_v;
        else if (cnt_en) cnt_out <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        if (cnt_en) en_n <= en_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input logic [31:0] v);
        ld_v = v;
        ld   = 1'b1;
        step();
        ld   = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            step();
            t++;
        end
        if (!rx_ready) check("send_timeout", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp);
        int t = 0;
        tx_ready = 1'b1;
        while (!tx_valid && t < 50) begin
            step();
            t++;
        end
        check(tag, {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, exp});
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cnt_out = '0;
        #1;
        step();
        step();
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_cnt_en", 32'(cnt_en), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_cnt_x", cnt_x, 32'd0);
        resetn = 1'b1;
        step();
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // ADD 5 from zero with exact latency
        set_cnt(32'h0);
        snap = en_n;
        send(8'h01); send(8'h05); send(8'h00); send(8'h00); send(8'h00);
        check("add_cnt_en", 32'(cnt_en), 32'd1);
        check("add_cnt_x", cnt_x, 32'h5);
        check("add_rx_ready_busy", 32'(rx_ready), 32'd0);
        step();
        check("add_cnt_en_off", 32'(cnt_en), 32'd0);
        check("add_latch_tx_valid", 32'(tx_valid), 32'd0);
        step();
        check("add_tx_valid_rise", 32'(tx_valid), 32'd1);
        recv("add_st", 8'h00); recv("add_b0", 8'h05); recv("add_b1", 8'h00);
        recv("add_b2", 8'h00); recv("add_b3", 8'h00);
        check("add_tx_idle", 32'(tx_valid), 32'd0);
        check("add_one_pulse", 32'(en_n - snap), 32'd1);

        // saturation belongs to the counter
        set_cnt(32'hFFFF_FFF0);
        send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
        check("sat_cnt_x", cnt_x, 32'h20);
        recv("sat_st", 8'h00); recv("sat_b0", 8'hFF); recv("sat_b1", 8'hFF);
        recv("sat_b2", 8'hFF); recv("sat_b3", 8'hFF);

        // READ under backpressure; counter changes mid-response
        set_cnt(32'h1234_5678);
        tx_ready = 1'b0;
        send(8'h02);
        check("rd_latch_tx_valid", 32'(tx_valid), 32'd0);
        step();
        check("rd_tx_valid_rise", 32'(tx_valid), 32'd1);
        set_cnt(32'h0000_DEAD);
        for (int i = 0; i < 9; i++) begin
            check("rd_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h00});
            step();
        end
        recv("rd_st", 8'h00); recv("rd_b0", 8'h78); recv("rd_b1", 8'h56);
        recv("rd_b2", 8'h34); recv("rd_b3", 8'h12);

        // illegal opcode, then normal READ
        snap = en_n;
        send(8'h7A);
        check("err_tx", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'hFF});
        recv("err_byte", 8'hFF);
        check("err_done_tx_valid", 32'(tx_valid), 32'd0);
        check("err_rx_ready", 32'(rx_ready), 32'd1);
        check("err_no_cnt_en", 32'(en_n - snap), 32'd0);
        send(8'h02);
        recv("err_rd_st", 8'h00); recv("err_rd_b0", 8'hAD); recv("err_rd_b1", 8'hDE);
        recv("err_rd_b2", 8'h00); recv("err_rd_b3", 8'h00);

        // reset in the middle of an ADD discards operand bytes
        snap = en_n;
        send(8'h01); send(8'hAA); send(8'hBB);
        resetn = 1'b0;
        step();
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        resetn = 1'b1;
        step();
        check("mid_rst_rx_ready_up", 32'(rx_ready), 32'd1);
        repeat (5) step();
        check("mid_rst_no_cnt_en", 32'(en_n - snap), 32'd0);
        set_cnt(32'h0);
        send(8'h01); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        check("mid_rst_cnt_x", cnt_x, 32'h1);
        recv("mid_rst_st", 8'h00); recv("mid_rst_b0", 8'h01); recv("mid_rst_b1", 8'h00);
        recv("mid_rst_b2", 8'h00); recv("mid_rst_b3", 8'h00);

        // second command waiting during a response
        send(8'h02);
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        check("pipe_latch_rx_ready", 32'(rx_ready), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("pipe_rx_ready_low", 32'(rx_ready), 32'd0);
            recv("pipe_byte", i == 1 ? 8'h01 : 8'h00);
        end
        check("pipe_rx_ready_up", 32'(rx_ready), 32'd1);
        step();
        rx_valid = 1'b0;
        check("pipe2_latch_tx_valid", 32'(tx_valid), 32'd0);
        check("pipe2_rx_ready", 32'(rx_ready), 32'd0);
        step();
        check("pipe2_tx_valid_rise", 32'(tx_valid), 32'd1);
        recv("pipe2_st", 8'h00); recv("pipe2_b0", 8'h01); recv("pipe2_b1", 8'h00);
        recv("pipe2_b2", 8'h00); recv("pipe2_b3", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_host.md
COUNTER_HOST -- requirements
Module: counter_host

Interface
REQ-001 Parameter: WIDTH, 32, counter data width in bits; SHALL be a multiple of 8 and at least 8; NB = WIDTH/8 bytes.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 rx_data  input  8  command byte stream from host.
REQ-005 rx_valid  input  1  rx_data valid.
REQ-006 rx_ready  output  1  block accepts rx_data; transfer when rx_valid and rx_ready at the same edge.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_valid  output  1  tx_data valid.
REQ-009 tx_ready  input  1  host accepts tx_data; transfer when tx_valid and tx_ready at the same edge.
REQ-010 cnt_en  output  1  increment strobe to the saturating counter.
REQ-011 cnt_x  output  WIDTH  increment amount, valid while cnt_en=1.
REQ-012 cnt_out  input  WIDTH  current counter value; reflects an increment one cycle after the cnt_en cycle.

Function
REQ-013 Opcodes: 0x01 ADD (followed by NB operand bytes, little-endian); 0x02 READ (no operands); any other value is illegal.
REQ-014 States: IDLE, ARG, ISSUE, LATCH, SEND_STATUS, SEND_DATA, SEND_ERR.
REQ-015 rx_ready SHALL be 1 only in IDLE and ARG; it SHALL be 0 in all other states.
REQ-016 IDLE: on an accepted 0x01 go to ARG with byte index 0; on 0x02 go to LATCH; on an illegal opcode go to SEND_ERR.
REQ-017 ARG: each accepted byte fills operand byte [index]; after byte NB-1 go to ISSUE.
REQ-018 ISSUE: cnt_en=1 and cnt_x=operand for exactly one cycle, then LATCH; cnt_en SHALL be 0 in every other state.
REQ-019 ADD latency: if the last operand byte is accepted in cycle N, then cnt_en=1 in N+1, cnt_out is captured in N+2, and tx_valid rises in N+3.
REQ-020 READ latency: if the opcode is accepted in cycle N, cnt_out is captured in N+1 and tx_valid rises in N+2.
REQ-021 LATCH: register cnt_out into the response shift register, then go to SEND_STATUS.
REQ-022 SEND_STATUS: tx_data=0x00; on transfer go to SEND_DATA.
REQ-023 SEND_DATA: emit the NB captured bytes LSB first; after the last transfer return to IDLE.
REQ-024 SEND_ERR: tx_data=0xFF; on transfer return to IDLE; no counter access.
REQ-025 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-026 The captured value SHALL NOT change during the response, even if cnt_out changes.
REQ-027 No arithmetic is done in the block; the operand is passed through unmodified; saturation belongs to the counter.
REQ-028 A new command is accepted only after the final response byte transfers; there is no pipelining of commands.

Reset
REQ-029 While resetn=0 at an edge: state becomes IDLE; byte index 0; operand 0; rx_ready, tx_valid and cnt_en are 0; tx_data and cnt_x are 0.
REQ-030 Reset in any state SHALL discard any partial command or response.
REQ-031 After reset, no cnt_en pulse SHALL follow from pre-reset bytes.
REQ-032 The first cycle after resetn rises, rx_ready=1.

Structure
REQ-033 Package counter_host_pkg SHALL hold: the opcode constants (OP_ADD=0x01, OP_READ=0x02), the status constants (ST_OK=0x00, ST_ERR=0xFF) and the state enumeration.
REQ-034 A single sub-module, counter_host_ser, SHALL implement the WIDTH-to-byte response serializer with the valid/ready hold rule.
REQ-035 The parser FSM and operand assembly SHALL reside in counter_host.

Verification
REQ-036 Counter model=0; send 01 05 00 00 00 -> one cnt_en cycle with cnt_x=0x00000005; response 00 05 00 00 00.
REQ-037 Counter model=0xFFFFFFF0; send ADD 0x20 -> response 00 FF FF FF FF.
REQ-038 Counter model=0x12345678; send 02 with tx_ready low for 10 cycles -> tx_valid=1 and tx_data=00 held stable, then bytes 78 56 34 12.
REQ-039 Send 0x7A -> response FF only; cnt_en never 1; next command 02 is serviced normally.
REQ-040 Assert resetn=0 for one cycle after 01 AA BB -> no cnt_en; then 01 01 00 00 00 -> cnt_x=0x00000001 (no stale bytes).
REQ-041 rx_valid held high with a second command during a response -> rx_ready=0 until the last response byte transfers; the second command then executes with correct latency.
